// File: rtl/isqrt_seq.sv
// -----------------------------------------------------------------------------
// isqrt_seq -- sequential integer square root, restoring digit-by-digit method.
//
// Accepts one WIDTH-bit unsigned operand through a valid/ready handshake,
// resolves BPC root bits per clock and presents the floor root, the remainder
// x - floor_root^2 and an optionally rounded root through a second
// valid/ready handshake.  One operation is in flight at a time.
//
// Parameters
//   WIDTH : operand width in bits, even and >= 4.
//   BPC   : root bits resolved per RUN cycle, 1 or 2, must divide WIDTH/2.
//
// Ports
//   clk       : clock, rising edge.
//   rst       : asynchronous, active-high reset.
//   in_valid  : operand offered by the producer.
//   in_ready  : block is idle and will accept an operand.
//   in_data   : unsigned operand x.
//   in_round  : 1 = round root to nearest, 0 = floor.
//   out_valid : result available.
//   out_ready : consumer accepts the result.
//   out_root  : root (floor or rounded).
//   out_rem   : x - floor_root^2, always from the unrounded root.
//   out_sat   : rounding would overflow the root; out_root saturated.
//   busy      : block is not idle.
//
// Latency from the accepting edge to out_valid is WIDTH/(2*BPC) edges.
// All outputs are registers; out_ready only steers the state register, so
// there is no combinational path from out_ready to in_ready.
// -----------------------------------------------------------------------------
module isqrt_seq #(
    parameter int WIDTH = 16,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] out_root,
    output logic [WIDTH/2:0]   out_rem,
    output logic               out_sat,
    output logic               busy
);

    // Root width, internal remainder width (two guard bits keep the trial
    // subtraction from truncating), iteration count and counter width.
    localparam int HW   = WIDTH / 2;
    localparam int RW   = HW + 2;
    localparam int ITER = WIDTH / (2 * BPC);
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0] ROOT_ONE = {{(HW-1){1'b0}}, 1'b1};

    // The fourth encoding is never entered by the next-state logic; if it is
    // ever reached it falls back to IDLE on the following edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          state_q,     state_d;
    logic [WIDTH-1:0] op_q,       op_d;
    logic [HW-1:0]   root_q,      root_d;
    logic [RW-1:0]   rem_q,       rem_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            round_q,     round_d;
    logic [HW-1:0]   out_root_q,  out_root_d;
    logic [HW:0]     out_rem_q,   out_rem_d;
    logic            out_sat_q,   out_sat_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q,  in_ready_d;
    logic            busy_q,      busy_d;

    // Results of this cycle's BPC iterations and the rounding decision.
    logic [WIDTH-1:0] op_s;
    logic [HW-1:0]    root_s;
    logic [RW-1:0]    rem_s;
    logic [RW-1:0]    trial_s;
    logic             round_up_s;
    logic [HW-1:0]    fin_root_s;
    logic             fin_sat_s;

    // Datapath: BPC restoring iterations chained within one cycle.
    always_comb begin
        op_s    = op_q;
        root_s  = root_q;
        rem_s   = rem_q;
        trial_s = {RW{1'b0}};
        for (int i = 0; i < BPC; i++) begin
            // Bring down the next two operand bits into the remainder.
            rem_s   = {rem_s[RW-3:0], op_s[WIDTH-1 -: 2]};
            op_s    = {op_s[WIDTH-3:0], 2'b00};
            // Trial divisor 4*root + 1; subtract only if it fits.
            trial_s = {root_s, 2'b01};
            if (rem_s >= trial_s) begin
                rem_s  = rem_s - trial_s;
                root_s = {root_s[HW-2:0], 1'b1};
            end else begin
                root_s = {root_s[HW-2:0], 1'b0};
            end
        end
    end

    // Rounding: x - r^2 > r is exactly the condition x > (r + 1/2)^2 for
    // integer x, so the remainder comparison selects round-to-nearest.
    always_comb begin
        round_up_s = round_q && (rem_s > {2'b00, root_s});
        fin_root_s = root_s;
        fin_sat_s  = 1'b0;
        if (round_up_s && (&root_s)) begin
            fin_root_s = root_s;
            fin_sat_s  = 1'b1;
        end else if (round_up_s) begin
            fin_root_s = root_s + ROOT_ONE;
            fin_sat_s  = 1'b0;
        end else begin
            fin_root_s = root_s;
            fin_sat_s  = 1'b0;
        end
    end

    // Next-state logic for the FSM, working registers and output registers.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        root_d     = root_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        round_d    = round_q;
        out_root_d = out_root_q;
        out_rem_d  = out_rem_q;
        out_sat_d  = out_sat_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = in_data;
                    round_d = in_round;
                    root_d  = {HW{1'b0}};
                    rem_d   = {RW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                op_d   = op_s;
                root_d = root_s;
                rem_d  = rem_s;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    // Final remainder <= 2*root, so the top guard bit is zero.
                    out_root_d = fin_root_s;
                    out_rem_d  = rem_s[HW:0];
                    out_sat_d  = fin_sat_s;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags are registered copies decoded from the next state.
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State, working and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= {WIDTH{1'b0}};
            root_q      <= {HW{1'b0}};
            rem_q       <= {RW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            round_q     <= 1'b0;
            out_root_q  <= {HW{1'b0}};
            out_rem_q   <= {(HW+1){1'b0}};
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            root_q      <= root_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            round_q     <= round_d;
            out_root_q  <= out_root_d;
            out_rem_q   <= out_rem_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_root  = out_root_q;
    assign out_rem   = out_rem_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_isqrt_seq -- self-checking bench for isqrt_seq.
// Three instances: WIDTH=16/BPC=1 (default), WIDTH=16/BPC=2, WIDTH=8/BPC=1.
// A behavioural model (plain integer square root) predicts every output and
// the handshake timing of each instance; one compare process checks all of
// them on every falling edge.
// -----------------------------------------------------------------------------
module tb_isqrt_seq;

    logic clk;
    logic rst;

    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] in_data   [3];
    logic        in_round  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [7:0]  out_root  [3];
    logic [8:0]  out_rem   [3];
    logic        out_sat   [3];
    logic        busy      [3];

    logic [3:0]  root2_s;
    logic [4:0]  rem2_s;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // Model state per instance.
    bit pending    [3];
    int acc_edge   [3];
    int exp_root   [3];
    int exp_rem    [3];
    int exp_sat    [3];
    int shown_root [3];
    int shown_rem  [3];
    int shown_sat  [3];

    isqrt_seq #(.WIDTH(16), .BPC(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_round(in_round[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_root(out_root[0]), .out_rem(out_rem[0]),
        .out_sat(out_sat[0]), .busy(busy[0])
    );

    isqrt_seq #(.WIDTH(16), .BPC(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_round(in_round[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_root(out_root[1]), .out_rem(out_rem[1]),
        .out_sat(out_sat[1]), .busy(busy[1])
    );

    isqrt_seq #(.WIDTH(8), .BPC(1)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2][7:0]), .in_round(in_round[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_root(root2_s), .out_rem(rem2_s),
        .out_sat(out_sat[2]), .busy(busy[2])
    );

    assign out_root[2] = {4'b0000, root2_s};
    assign out_rem[2]  = {4'b0000, rem2_s};

    function automatic int w_of(input int i);
        return (i == 2) ? 8 : 16;
    endfunction

    function automatic int iter_of(input int i);
        return (i == 0) ? 8 : 4;
    endfunction

    // Reference: floor root by search, remainder, then the rounding rules.
    function automatic void ref_calc(input int x, input int w, input bit rnd,
                                     output int r, output int rm, output int s);
        int hmax;
        hmax = (1 << (w / 2)) - 1;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        rm = x - r * r;
        s  = 0;
        if (rnd && rm > r) begin
            if (r == hmax) s = 1;
            else           r = r + 1;
        end
    endfunction

    // Operand generator biased toward squares and rounding boundaries.
    function automatic logic [15:0] gen_x(input int w);
        int hmax, xmax, k, x;
        hmax = (1 << (w / 2)) - 1;
        xmax = (1 << w) - 1;
        k    = int'($urandom_range(hmax, 0));
        case ($urandom_range(5, 0))
            0:       x = k * k + k;
            1:       x = k * k + k + 1;
            2:       x = k * k - 1;
            3:       x = xmax;
            4:       x = k * k;
            default: x = int'($urandom_range(xmax, 0));
        endcase
        if (x < 0)    x = 0;
        if (x > xmax) x = xmax;
        return 16'(x);
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d: actual %0d required %0d (t=%0t)", nm, i, act, req, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
        end
    end

    // Compare process: model prediction versus every instance, each cycle.
    initial begin
        bit exp_v;
        bit acc;
        int mask;
        for (int i = 0; i < 3; i++) begin
            pending[i] = 1'b0; shown_root[i] = 0; shown_rem[i] = 0; shown_sat[i] = 0;
            acc_edge[i] = 0; exp_root[i] = 0; exp_rem[i] = 0; exp_sat[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    pending[i] = 1'b0;
                    shown_root[i] = 0; shown_rem[i] = 0; shown_sat[i] = 0;
                    chk("rst_valid", i, int'(out_valid[i]), 0);
                    chk("rst_busy",  i, int'(busy[i]), 0);
                    chk("rst_root",  i, int'(out_root[i]), 0);
                    chk("rst_rem",   i, int'(out_rem[i]), 0);
                    chk("rst_sat",   i, int'(out_sat[i]), 0);
                end else begin
                    exp_v = pending[i] && ((edge_cnt - acc_edge[i]) >= iter_of(i));
                    if (exp_v) begin
                        shown_root[i] = exp_root[i];
                        shown_rem[i]  = exp_rem[i];
                        shown_sat[i]  = exp_sat[i];
                    end
                    chk("out_valid", i, int'(out_valid[i]), int'(exp_v));
                    chk("busy",      i, int'(busy[i]), int'(pending[i]));
                    chk("in_ready",  i, int'(in_ready[i]), int'(!pending[i]));
                    chk("out_root",  i, int'(out_root[i]), shown_root[i]);
                    chk("out_rem",   i, int'(out_rem[i]), shown_rem[i]);
                    chk("out_sat",   i, int'(out_sat[i]), shown_sat[i]);
                    acc = in_valid[i] && !pending[i];
                    if (exp_v && out_ready[i]) pending[i] = 1'b0;
                    if (acc) begin
                        mask = (1 << w_of(i)) - 1;
                        ref_calc(int'(in_data[i]) & mask, w_of(i), in_round[i],
                                 exp_root[i], exp_rem[i], exp_sat[i]);
                        pending[i]  = 1'b1;
                        acc_edge[i] = edge_cnt + 1;
                    end
                end
            end
        end
    end

    // One directed operation on the default instance with literal results.
    task automatic directed(input int x, input bit rnd, input int er, input int erm,
                            input int es, input int stall);
        int n;
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = x[15:0]; in_round[0] = rnd; out_ready[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(in_valid[0] && in_ready[0]) && n < 50) begin
            @(negedge clk); n++;
        end
        chk("dir_accept", 0, int'(in_ready[0]), 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0; in_data[0] = 16'($urandom); in_round[0] = !rnd;
        n = 0;
        @(negedge clk);
        while (!out_valid[0] && n < 40) begin
            @(negedge clk); n++;
        end
        chk("dir_valid", 0, int'(out_valid[0]), 1);
        chk("dir_root",  0, int'(out_root[0]), er);
        chk("dir_rem",   0, int'(out_rem[0]), erm);
        chk("dir_sat",   0, int'(out_sat[0]), es);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("bp_valid",    0, int'(out_valid[0]), 1);
            chk("bp_in_ready", 0, int'(in_ready[0]), 0);
            chk("bp_root",     0, int'(out_root[0]), er);
            chk("bp_rem",      0, int'(out_rem[0]), erm);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("post_in_ready", 0, int'(in_ready[0]), 1);
        chk("post_valid",    0, int'(out_valid[0]), 0);
        chk("post_root",     0, int'(out_root[0]), er);
        chk("post_rem",      0, int'(out_rem[0]), erm);
        chk("post_sat",      0, int'(out_sat[0]), es);
    endtask

    // Random operands with random producer gaps and consumer stalls.
    task automatic rand_run(input int i, input int n);
        int acc;
        int cyc;
        bit fire;
        acc = 0; cyc = 0;
        in_valid[i] = 1'b0;
        while (acc < n && cyc < 30000) begin
            @(negedge clk);
            fire = in_valid[i] && in_ready[i];
            @(posedge clk); #1;
            cyc++;
            if (fire) begin
                acc++;
                in_valid[i] = 1'b0;
            end
            if (!in_valid[i]) begin
                in_data[i]  = 16'($urandom);
                in_round[i] = 1'($urandom);
                if (acc < n && $urandom_range(3, 0) != 0) begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = gen_x(w_of(i));
                end
            end
            out_ready[i] = ($urandom_range(3, 0) != 0);
        end
        chk("rand_accepts", i, acc, n);
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b1;
        repeat (iter_of(i) + 6) @(posedge clk);
        #1;
    endtask

    initial begin
        int r, rm, s;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_data[i] = 16'h0000; in_round[i] = 1'b0; out_ready[i] = 1'b1;
        end

        // Pin the model itself to hand-computed values.
        ref_calc(65535, 16, 1'b1, r, rm, s);
        chk("model_ffff_root", 0, r, 255); chk("model_ffff_rem", 0, rm, 510); chk("model_ffff_sat", 0, s, 1);
        ref_calc(210, 16, 1'b1, r, rm, s);
        chk("model_210_root", 0, r, 14); chk("model_210_rem", 0, rm, 14);
        ref_calc(211, 16, 1'b1, r, rm, s);
        chk("model_211_root", 0, r, 15); chk("model_211_rem", 0, rm, 15);
        ref_calc(255, 8, 1'b1, r, rm, s);
        chk("model_w8_root", 2, r, 15); chk("model_w8_sat", 2, s, 1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 0, int'(in_ready[0]), 1);
        chk("reset_root",     0, int'(out_root[0]), 0);
        chk("reset_valid",    0, int'(out_valid[0]), 0);

        directed(0,     1'b0, 0,   0,   0, 0);
        directed(65535, 1'b0, 255, 510, 0, 0);
        directed(65535, 1'b1, 255, 510, 1, 0);
        directed(210,   1'b1, 14,  14,  0, 0);
        directed(211,   1'b1, 15,  15,  0, 0);
        directed(211,   1'b0, 14,  15,  0, 0);
        directed(200,   1'b0, 14,  4,   0, 5);

        // Reset during the third RUN cycle discards the operation.
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = 16'd5000; in_round[0] = 1'b0; out_ready[0] = 1'b1;
        @(negedge clk);
        chk("mid_accept", 0, int'(in_ready[0]), 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  0, int'(busy[0]), 0);
        chk("mid_rst_valid", 0, int'(out_valid[0]), 0);
        chk("mid_rst_root",  0, int'(out_root[0]), 0);
        chk("mid_rst_rem",   0, int'(out_rem[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        directed(144, 1'b0, 12, 0, 0, 0);

        rand_run(0, 300);
        rand_run(1, 1000);
        rand_run(2, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
